// File: rtl/zeroriscy_lockstep_soc.sv
// Dual-lane lockstep SoC top. Two identical lanes each walk a fixed
// program of N_ITER steps, advancing a sequential fetch address and
// accumulating a checksum. A comparator publishes the agreed checksum
// once both lanes are done, or ERR_CODE if the lanes disagree.
//
// Handshake: there is no valid/ready pair here; fetch_enable_i_N is a
// level-sensitive run enable sampled on every rising edge, and mem_flag
// is a sticky "result valid" indicator that stays set until reset.
module zeroriscy_lockstep_soc #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080,
  parameter int unsigned N_ITER    = 10,
  parameter logic [31:0] ERR_CODE  = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i_1,
  input  logic        fetch_enable_i_2,
  output logic [31:0] mem_flag,
  output logic [31:0] mem_result,
  output logic [31:0] instr_addr1,
  output logic [31:0] instr_addr2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lane_state_t;

  localparam logic [31:0] N_ITER_W = 32'(N_ITER);

  // Lane state, visible hierarchically for checkers and fault injection.
  lane_state_t lane1_state;
  lane_state_t lane2_state;
  logic [31:0] cnt1;
  logic [31:0] cnt2;
  logic [31:0] acc1;
  logic [31:0] acc2;

  // Lane 1: IDLE -> RUN on enable, one program step per enabled edge, DONE after N_ITER steps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane1_state <= IDLE;
      cnt1        <= '0;
      acc1        <= '0;
      instr_addr1 <= BOOT_ADDR;
    end else begin
      case (lane1_state)
        IDLE: begin
          if (fetch_enable_i_1) lane1_state <= RUN;
        end
        RUN: begin
          if (fetch_enable_i_1) begin
            cnt1        <= cnt1 + 32'd1;
            acc1        <= acc1 + cnt1 + 32'd1;
            instr_addr1 <= instr_addr1 + 32'd4;
            if (cnt1 + 32'd1 == N_ITER_W) lane1_state <= DONE;
          end
        end
        DONE: begin
          lane1_state <= DONE;
        end
        default: lane1_state <= IDLE;
      endcase
    end
  end

  // Lane 2: identical to lane 1, driven by its own enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane2_state <= IDLE;
      cnt2        <= '0;
      acc2        <= '0;
      instr_addr2 <= BOOT_ADDR;
    end else begin
      case (lane2_state)
        IDLE: begin
          if (fetch_enable_i_2) lane2_state <= RUN;
        end
        RUN: begin
          if (fetch_enable_i_2) begin
            cnt2        <= cnt2 + 32'd1;
            acc2        <= acc2 + cnt2 + 32'd1;
            instr_addr2 <= instr_addr2 + 32'd4;
            if (cnt2 + 32'd1 == N_ITER_W) lane2_state <= DONE;
          end
        end
        DONE: begin
          lane2_state <= DONE;
        end
        default: lane2_state <= IDLE;
      endcase
    end
  end

  // Comparator: publish once when both lanes are done; result and flag are sticky until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_flag   <= '0;
      mem_result <= '0;
    end else if (lane1_state == DONE && lane2_state == DONE && mem_flag == 32'd0) begin
      mem_result <= (acc1 == acc2) ? acc1 : ERR_CODE;
      mem_flag   <= 32'd1;
    end
  end

endmodule

// File: tb/tb_zeroriscy_lockstep_soc.sv
// Bench for zeroriscy_lockstep_soc: a lane-level reference model predicts
// fetch addresses and flag timing; a queue holds the expected published result.
module tb_zeroriscy_lockstep_soc;

  localparam logic [31:0] BOOT = 32'h0000_0080;
  localparam int          N    = 10;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en1 = 1'b0;
  logic en2 = 1'b0;
  logic [31:0] mem_flag, mem_result, addr1, addr2;

  always #5 clk = ~clk;

  zeroriscy_lockstep_soc dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .fetch_enable_i_1(en1),
    .fetch_enable_i_2(en2),
    .mem_flag        (mem_flag),
    .mem_result      (mem_result),
    .instr_addr1     (addr1),
    .instr_addr2     (addr2)
  );

  // Scoreboard and reference model
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int          m_st[2];     // 0 idle, 1 run, 2 done
  int          m_steps[2];
  bit          m_flag;
  logic [31:0] m_res;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one edge, advance the model, then compare every output.
  task automatic step(input logic r, input logic e1, input logic e2);
    bit   both_done;
    logic e[2];
    rst  = r;
    en1  = e1;
    en2  = e2;
    e[0] = e1;
    e[1] = e2;
    @(posedge clk);
    both_done = (m_st[0] == 2) && (m_st[1] == 2);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i]    = 0;
        m_steps[i] = 0;
      end
      m_flag = 1'b0;
      m_res  = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_st[i])
          0: if (e[i]) m_st[i] = 1;
          1: if (e[i]) begin
               m_steps[i]++;
               if (m_steps[i] == N) m_st[i] = 2;
             end
          default: ;
        endcase
      end
      if (both_done && !m_flag) begin
        m_flag = 1'b1;
        check_val("sb_avail", 32'(exp_q.size() > 0), 32'd1);
        m_res = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      end
    end
    #1;
    check_val("addr1", addr1, BOOT + 32'(4 * m_steps[0]));
    check_val("addr2", addr2, BOOT + 32'(4 * m_steps[1]));
    check_val("flag", mem_flag, {31'b0, m_flag});
    check_val("result", mem_result, m_flag ? m_res : 32'd0);
  endtask

  // Reset held for three edges; any unconsumed expectation is an error.
  task automatic do_reset();
    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check_val("rst_addr1", addr1, BOOT);
    check_val("rst_addr2", addr2, BOOT);
    check_val("rst_flag", mem_flag, 32'd0);
    check_val("rst_res", mem_result, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_st[i]    = 0;
      m_steps[i] = 0;
    end
    m_flag = 1'b0;
    m_res  = '0;

    // Test 1/2: reset, then a clean run with both enables high.
    do_reset();
    exp_q.push_back(32'h37);
    for (int k = 1; k <= 11; k++) step(1'b0, 1'b1, 1'b1);
    check_val("t1_flag_e11", mem_flag, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check_val("t1_flag_e12", mem_flag, 32'd1);
    check_val("t1_res_e12", mem_result, 32'h37);
    for (int k = 0; k < 5; k++) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
    check_val("t1_addr1_end", addr1, 32'hA8);
    check_val("t1_res_sticky", mem_result, 32'h37);

    // Test 3: lane 2 stalls for four edges mid-run.
    do_reset();
    exp_q.push_back(32'h37);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b1);
    check_val("t3_addr2_pre", addr2, 32'h8C);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
    check_val("t3_addr2_frozen", addr2, 32'h8C);
    for (int k = 9; k <= 15; k++) step(1'b0, 1'b1, 1'b1);
    check_val("t3_flag_e15", mem_flag, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check_val("t3_flag_e16", mem_flag, 32'd1);
    check_val("t3_res", mem_result, 32'h37);

    // Test 4: lane 1 never enabled; comparator waits forever.
    do_reset();
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b1);
    check_val("t4_flag", mem_flag, 32'd0);
    check_val("t4_addr2", addr2, 32'hA8);
    check_val("t4_addr1", addr1, BOOT);

    // Test 5: corrupt lane 1 checksum so the lanes disagree.
    do_reset();
    exp_q.push_back(ERR);
    force dut.acc1 = 32'h0000_1234;
    for (int k = 0; k < 14; k++) step(1'b0, 1'b1, 1'b1);
    release dut.acc1;
    check_val("t5_flag", mem_flag, 32'd1);
    check_val("t5_res", mem_result, ERR);

    // Test 6: reset asserted at edge 6 of a run, then a full run.
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check_val("t6_addr1", addr1, BOOT);
    check_val("t6_addr2", addr2, BOOT);
    check_val("t6_flag", mem_flag, 32'd0);
    exp_q.push_back(32'h37);
    for (int k = 1; k <= 13; k++) step(1'b0, 1'b1, 1'b1);
    check_val("t6_res", mem_result, 32'h37);
    check_val("t6_flag_end", mem_flag, 32'd1);

    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
